// File: rtl/xlib_dma_bst_arb_pkg.sv
// Shared types and helpers for the DMA burst arbiter.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package xlib_dma_bst_arb_pkg;

  // Upper bound on channel count; sizes the request vector of the round-robin helper.
  localparam int MAX_NCH = 16;

  // ARB: looking for a winner. CMD: burst command on the bus until accepted.
  typedef enum logic {
    ARB = 1'b0,
    CMD = 1'b1
  } state_t;

  // Burst length code: Avalon/VCI count the words, AXI counts words minus one.
  function automatic int bcnt_code(input int bl, input int blen_type);
    return (blen_type != 0) ? ((1 << bl) - 1) : (1 << bl);
  endfunction

  // First set bit of req, searching from ptr+1 upward with wrap modulo nch.
  // Walking the distance downward lets the nearest requester overwrite farther ones.
  function automatic int rr_pick(input logic [MAX_NCH-1:0] req, input int ptr, input int nch);
    int idx;
    int res;
    res = ptr;
    for (int i = nch; i >= 1; i--) begin
      idx = (ptr + i) % nch;
      if (req[idx[3:0]]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/xlib_dma_bst_arb_if.sv
// Avalon/VCI read-master command and response-strobe bundle.
// Latency: wires only.
// Backpressure: avm_waitrequest stalls the command held by the master.
interface xlib_dma_bst_arb_if #(
  parameter int AW  = 32,
  parameter int BCW = 5
);
  logic [AW-1:0]  avm_address;
  logic [BCW-1:0] avm_burstcount;
  logic           avm_read;
  logic           avm_waitrequest;
  logic           avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_burstcount,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_burstcount,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdatavalid
  );
endinterface

// File: rtl/xlib_dma_tag_fifo.sv
// In-order FIFO of burst owner tags, depth 2**OW, with occupancy count.
// Latency: push visible at head next cycle when empty; pop advances head next cycle.
// Backpressure: none internally; the caller must not push when full nor pop when empty.
module xlib_dma_tag_fifo #(
  parameter int W  = 2,
  parameter int OW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [OW:0]   count
);
  localparam int DEPTH = 1 << OW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [OW-1:0] wr_q;
  logic [OW-1:0] rd_q;
  logic [OW:0]   cnt_q;

  // Storage, wrapping pointers and count; push+pop together keep the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_dat;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/xlib_dma_bst_arb.sv
// Round-robin arbiter sharing one burst read master between NCH DMA channels.
// Latency: ch_req sampled -> avm_read 1 cycle; ack combinational on bus acceptance.
// Backpressure: avm_waitrequest holds the command; grants stop while 2**OW bursts are outstanding.
module xlib_dma_bst_arb
  import xlib_dma_bst_arb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CW        = 2,
  parameter int AW        = 32,
  parameter int BL        = 4,
  parameter int BLEN_TYPE = 0,
  parameter int OW        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH*AW-1:0]   ch_adr,
  output logic [NCH-1:0]      ch_ack,
  output logic [NCH-1:0]      ch_rsp_val,
  output logic [CW-1:0]       rsp_ch,
  output logic                busy,
  output logic                err,
  xlib_dma_bst_arb_if.master  avm
);
  localparam int             BCW   = BL - BLEN_TYPE + 1;
  localparam logic [BCW-1:0] BCNT  = BCW'(bcnt_code(BL, BLEN_TYPE));
  localparam logic [OW:0]    DEPTH = (OW+1)'(1) << OW;

  state_t               state_q, state_d;
  logic                 grant;
  logic                 accept;
  logic [CW-1:0]        win;
  logic [MAX_NCH-1:0]   req_ext;
  logic [CW-1:0]        owner_q;
  logic [CW-1:0]        ptr_q;
  logic [AW-1:0]        adr_q;
  logic [AW-1:0]        adr_arr [NCH];

  logic [BL-1:0]        beat_q;
  logic                 beat_vld;
  logic                 err_q;

  logic                 tag_pop;
  logic [CW-1:0]        tag_head;
  logic                 tag_empty;
  logic [OW:0]          tag_cnt;

  for (genvar g = 0; g < NCH; g++) begin : g_adr
    assign adr_arr[g] = ch_adr[g*AW +: AW];
  end

  // Next state: grant only with a free tag slot (count is registered, so a same-cycle pop does not help).
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    accept  = 1'b0;
    req_ext = '0;
    req_ext[NCH-1:0] = ch_req;
    win     = CW'(rr_pick(req_ext, int'(ptr_q), NCH));
    case (state_q)
      ARB: begin
        if ((|ch_req) && (tag_cnt < DEPTH)) begin
          grant   = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (!avm.avm_waitrequest) begin
          accept  = 1'b1;
          state_d = ARB;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end

  // Owner and address are captured at grant only; the pointer moves when the bus takes the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      adr_q   <= '0;
      ptr_q   <= CW'(NCH-1);
    end else begin
      if (grant) begin
        owner_q <= win;
        adr_q   <= adr_arr[win];
      end
      if (accept) ptr_q <= owner_q;
    end
  end

  // Beat counter over routed beats; stray beats only raise the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (beat_vld) beat_q <= beat_q + 1'b1;
      if (avm.avm_readdatavalid && tag_empty) err_q <= 1'b1;
    end
  end

  xlib_dma_tag_fifo #(
    .W  (CW),
    .OW (OW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat (owner_q),
    .pop      (tag_pop),
    .head     (tag_head),
    .empty    (tag_empty),
    .count    (tag_cnt)
  );

  assign beat_vld           = avm.avm_readdatavalid & ~tag_empty;
  assign tag_pop            = beat_vld & (&beat_q);

  assign avm.avm_read       = (state_q == CMD);
  assign avm.avm_address    = adr_q;
  assign avm.avm_burstcount = BCNT;

  assign ch_ack     = accept ? (NCH'(1) << owner_q) : '0;
  assign ch_rsp_val = beat_vld ? (NCH'(1) << tag_head) : '0;
  assign rsp_ch     = tag_head;
  assign busy       = (state_q == CMD) | ~tag_empty;
  assign err        = err_q;

endmodule

// File: doc/xlib_dma_bst_arb.md
Name: xlib_dma_bst_arb

Overview:
- Round-robin burst arbiter that shares one Avalon/VCI read master between NCH compact burst-read DMA channels.
- Each channel presents a burst request and address. The arbiter issues whole fixed-length bursts and pulses the owner's ack on acceptance.
- An in-order tag FIFO routes each returning readdatavalid beat to the channel that issued the burst.
- Read data itself is wired directly from the bus to every channel FIFO; only the valid strobe is steered.

Parameters:
- NCH, 4, number of DMA channels (2..16)
- CW, 2, channel index width, log2(NCH)
- AW, 32, address width
- BL, 4, burst length width; burst = 2**BL words; BL>0
- BLEN_TYPE, 0, 0 = VCI/AVM burstcount 2**BL; 1 = AXI len 2**BL-1
- OW, 3, outstanding-burst FIFO width; depth = 2**OW bursts

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_req  in  NCH  per-channel burst request (biu_req of each engine)
- ch_adr  in  NCH*AW  per-channel burst address; channel i at [i*AW +: AW]
- ch_ack  out  NCH  one-cycle pulse when channel's burst is accepted by the bus
- ch_rsp_val  out  NCH  routed readdatavalid, one-hot or zero
- avm_address  out  AW  bus address
- avm_burstcount  out  BL-BLEN_TYPE+1  burst length code
- avm_read  out  1  bus read request
- avm_waitrequest  in  1  bus stall
- avm_readdatavalid  in  1  bus response beat
- rsp_ch  out  CW  owner index of the current response beat (valid with avm_readdatavalid)
- busy  out  1  command pending or bursts outstanding
- err  out  1  sticky: readdatavalid arrived with no outstanding burst

Behaviour:
- Reset values: avm_read=0, avm_address=0, ch_ack=0, ch_rsp_val=0, err=0, busy=0, rsp_ch=0, round-robin pointer=NCH-1, FIFO empty, beat counter=0.
- avm_burstcount is constant: BLEN_TYPE ? 2**BL-1 : 2**BL.
- FSM states:
  - ARB: a grant is made when any ch_req is set and FIFO count < 2**OW (a pending pop does not free a slot in that same cycle).
    - Winner is the first requester searching from ptr+1 upward with modulo-NCH wrap.
    - On grant: latch owner and ch_adr[owner] into registers, set avm_read=1 on the next edge, go to CMD.
    - Latency from ch_req sampled to avm_read high is 1 cycle.
  - CMD: avm_read=1 with the latched address held stable.
    - Acceptance is avm_read & ~avm_waitrequest.
    - On acceptance, in the same cycle: ch_ack[owner]=1 (combinational), push owner into the tag FIFO, ptr<=owner.
    - Next edge: avm_read=0, return to ARB.
    - Back-to-back bursts therefore occur at most every 2 cycles.
- A granted command is committed. A ch_req drop during CMD is ignored; the burst completes and ack is still pulsed.
- The address is taken only at grant; later ch_adr changes are ignored until the next grant.
- Response routing:
  - rsp_ch = FIFO head.
  - ch_rsp_val[head] = avm_readdatavalid when the FIFO is non-empty; else all zero.
  - A beat counter (BL bits) counts valid beats. On the 2**BL-th beat (counter all ones) the FIFO pops and the counter wraps to 0.
- Push and pop in the same cycle leave the count unchanged and are both honoured; the FIFO pointers wrap modulo 2**OW.
- Stray beat: avm_readdatavalid with the FIFO empty sets err (sticky until reset), is not routed, and leaves the counter unchanged.
- busy = (state==CMD) | FIFO non-empty.
- Asserting reset mid-burst clears everything immediately. Any outstanding responses arriving after reset are stray and set err. Channels must be reset together with the arbiter.

Decomposition:
- Shared package holds:
  - burstcount code function of BL and BLEN_TYPE
  - state encoding (ARB, CMD)
  - round-robin find-first function (req vector, pointer) -> index
- One sub-module: xlib_dma_tag_fifo, a synchronous FIFO of CW-bit entries, depth 2**OW, with count output and simultaneous push/pop.

Test Plan (NCH=4, BL=2, OW=2, AVM):
- Single channel: ch_req[1]=1, adr=0x100, waitrequest=0 -> avm_read 1 cycle later with address 0x100 and burstcount 4; ch_ack[1] pulses 1 cycle; 4 readdatavalid beats give ch_rsp_val[1] x4 and rsp_ch=1; FIFO empty, busy=0.
- Contention: ch_req=4'b1011 held with ack-driven address increments -> grant order 0,1,3,0,1,3; responses routed in the same order, 4 beats each.
- Backpressure: waitrequest=1 for 5 cycles during CMD -> avm_read and address stable all 5 cycles, no ack; ack fires on the first cycle with waitrequest=0.
- FIFO full: 4 bursts accepted with no responses -> no 5th avm_read. The 4th beat of the first burst pops the FIFO, and the next grant follows 1 cycle later.
- Stray beat and reset: readdatavalid with the FIFO empty -> err=1, ch_rsp_val=0. Then rst_n low mid-CMD -> avm_read=0 and err=0 immediately.
